dmem_arbiter: RTL and testbench

- Shares the single Data_Memory port between the core LSU and one external master (DMA/debug loader).
- Sits between the LSU write/address outputs and Data_Memory.
- Core has default priority. A wait counter guarantees the external master a slot after MAX_WAIT consecutive losses.
- When the external master wins, the arbiter asserts core_stall. Top level gates pcReg update and regFile write with core_stall.

---
 rtl/dmem_arbiter_if.sv | 46 ++++
 rtl/dmem_arbiter.sv | 99 +++++++++
 tb/tb_dmem_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Shared Data_Memory port bundle: core LSU side, external master side and the memory itself.
// The arbiter takes the slave view; whoever hosts the requesters and the RAM takes the master view.
interface dmem_arbiter_if #(
    parameter int WIDTH = 32
);
    // Core LSU
    logic             core_req;
    logic             core_we;
    logic [WIDTH-1:0] core_addr;
    logic [WIDTH-1:0] core_wdata;
    logic [WIDTH-1:0] core_rdata;
    logic             core_stall;

    // External master (DMA / debug loader)
    logic             dma_req;
    logic             dma_we;
    logic [WIDTH-1:0] dma_addr;
    logic [WIDTH-1:0] dma_wdata;
    logic             dma_gnt;
    logic [WIDTH-1:0] dma_rdata;
    logic             dma_rvalid;

    // Data_Memory port
    logic [WIDTH-1:0] mem_A;
    logic [WIDTH-1:0] mem_in_Data;
    logic             mem_WE;
    logic [WIDTH-1:0] mem_o_Data;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_rdata, core_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rdata, dma_rvalid,
        output mem_A, mem_in_Data, mem_WE,
        input  mem_o_Data
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_rdata, core_stall,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rdata, dma_rvalid,
        input  mem_A, mem_in_Data, mem_WE,
        output mem_o_Data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Arbitrates the single Data_Memory port between the core LSU (default priority) and an external
// master that is forced a slot after MAX_WAIT consecutive losses. Macro DMEM_ARB_STATS_EN adds counters.
module dmem_arbiter #(
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 3
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]   stall_cnt,
    output logic [31:0]   dma_xfer_cnt
`endif
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CORE,
        OWN_DMA
    } owner_t;

    owner_t           owner;
    logic [CNT_W-1:0] waitCnt;
    logic             waitSat;
    logic             dmaGnt;
    logic             dmaRead;
    logic             coreStall;
    logic             rvalidQ;
    logic [WIDTH-1:0] rdataQ;

    assign waitSat = (waitCnt == CNT_W'(MAX_WAIT));

    // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
    always_comb begin
        owner = OWN_NONE;
        if (!rst) begin
            if (bus.dma_req && (!bus.core_req || waitSat)) begin
                owner = OWN_DMA;
            end else if (bus.core_req) begin
                owner = OWN_CORE;
            end
        end
    end

    assign dmaGnt    = (owner == OWN_DMA);
    assign dmaRead   = dmaGnt && !bus.dma_we;
    assign coreStall = bus.core_req && dmaGnt;

    // Port mux: the owner's write enable only, so a stalled or resetting core never writes.
    assign bus.mem_A       = dmaGnt ? bus.dma_addr  : bus.core_addr;
    assign bus.mem_in_Data = dmaGnt ? bus.dma_wdata : bus.core_wdata;
    assign bus.mem_WE      = dmaGnt ? bus.dma_we    : ((owner == OWN_CORE) && bus.core_we);

    assign bus.core_rdata = bus.mem_o_Data;
    assign bus.core_stall = coreStall;
    assign bus.dma_gnt    = dmaGnt;
    assign bus.dma_rdata  = rdataQ;
    assign bus.dma_rvalid = rvalidQ;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            waitCnt <= '0;
            rvalidQ <= 1'b0;
            rdataQ  <= '0;
        end else begin
            // The streak only counts consecutive losses; a grant or a dropped request restarts it.
            if (!bus.dma_req || dmaGnt) begin
                waitCnt <= '0;
            end else if (!waitSat) begin
                waitCnt <= waitCnt + CNT_W'(1);
            end

            rvalidQ <= dmaRead;
            if (dmaRead) begin
                rdataQ <= bus.mem_o_Data;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt    <= '0;
            dma_xfer_cnt <= '0;
        end else begin
            if (coreStall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (dmaGnt) begin
                dma_xfer_cnt <= dma_xfer_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic against a
// cycle-level reference model that tracks the memory image, the loss streak and the read return.
module tb_dmem_arbiter;
    localparam int MAX_WAIT = 3;

    logic clk;
    logic rst;

    dmem_arbiter_if #(.WIDTH(32)) bus ();

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stallCnt;
    logic [31:0] dmaXferCnt;
`endif

    dmem_arbiter #(
        .WIDTH   (32),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stall_cnt   (stallCnt),
        .dma_xfer_cnt(dmaXferCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data_Memory stand-in: combinational read, write on the rising edge, plus a preload port.
    logic [31:0] mem [256] = '{default: 32'h0};
    logic        pokeEn;
    int          pokeIdx;
    logic [31:0] pokeData;

    always @(posedge clk) begin
        if (bus.mem_WE) mem[bus.mem_A[9:2]] <= bus.mem_in_Data;
        if (pokeEn) mem[pokeIdx] <= pokeData;
    end
    assign bus.mem_o_Data = mem[bus.mem_A[9:2]];

    int nVec = 0;
    int nErr = 0;

    // Reference model state
    logic [31:0] refMem [256];
    int          denied;
    logic        expRvalid;
    logic [31:0] expRdata;
    logic [31:0] expStallCnt;
    logic [31:0] expXferCnt;
    logic        expGnt;
    logic        expStall;
    logic        expWe;
    logic [31:0] expA;
    logic [31:0] expWd;

    function automatic int widx(logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    // Port owner this cycle: core unless the master has lost MAX_WAIT times in a row.
    task automatic model_eval();
        expGnt   = !rst && bus.dma_req && (!bus.core_req || denied >= MAX_WAIT);
        expStall = bus.core_req && expGnt;
        expWe    = rst ? 1'b0 : (expGnt ? bus.dma_we : (bus.core_req && bus.core_we));
        expA     = expGnt ? bus.dma_addr : bus.core_addr;
        expWd    = expGnt ? bus.dma_wdata : bus.core_wdata;
    endtask

    task automatic model_commit();
        if (pokeEn) refMem[pokeIdx] = pokeData;
        if (rst) begin
            denied      = 0;
            expRvalid   = 1'b0;
            expRdata    = 32'h0;
            expStallCnt = 32'h0;
            expXferCnt  = 32'h0;
        end else begin
            expRvalid = expGnt && !bus.dma_we;
            if (expRvalid) expRdata = refMem[widx(bus.dma_addr)];
            if (expWe) refMem[widx(expA)] = expWd;
            if (bus.dma_req && !expGnt) denied = (denied < MAX_WAIT) ? denied + 1 : denied;
            else denied = 0;
            expStallCnt = expStallCnt + 32'(expStall);
            expXferCnt  = expXferCnt + 32'(expGnt);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic tick();
        model_eval();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.core_req = 1'b0;
        bus.core_we  = 1'b0;
        bus.dma_req  = 1'b0;
        bus.dma_we   = 1'b0;
    endtask

    task automatic test_reset();
        bus.dma_req   = 1'b1;
        bus.dma_we    = 1'b1;
        bus.dma_addr  = 32'h80;
        bus.dma_wdata = 32'hA5A5_0001;
        for (int i = 0; i < 2; i++) begin
            settle();
            nVec++; if (bus.dma_gnt !== 1'b0) begin nErr++; $display("FAIL reset_gnt[%0d]: got %b want 0", i, bus.dma_gnt); end
            nVec++; if (bus.mem_WE !== 1'b0) begin nErr++; $display("FAIL reset_we[%0d]: got %b want 0", i, bus.mem_WE); end
            nVec++; if (bus.core_stall !== 1'b0) begin nErr++; $display("FAIL reset_stall[%0d]: got %b want 0", i, bus.core_stall); end
            nVec++; if (bus.dma_rvalid !== 1'b0) begin nErr++; $display("FAIL reset_rvalid[%0d]: got %b want 0", i, bus.dma_rvalid); end
            nVec++; if (bus.dma_rdata !== 32'h0) begin nErr++; $display("FAIL reset_rdata[%0d]: got %h want 0", i, bus.dma_rdata); end
            tick();
        end
        nVec++; if (mem[32] !== 32'h0) begin nErr++; $display("FAIL reset_mem: got %h want 0", mem[32]); end
        rst = 1'b0;
        settle();
        nVec++; if (bus.dma_gnt !== 1'b1) begin nErr++; $display("FAIL release_gnt: got %b want 1", bus.dma_gnt); end
        nVec++; if (bus.mem_WE !== 1'b1) begin nErr++; $display("FAIL release_we: got %b want 1", bus.mem_WE); end
        tick();
        idle();
        tick();
        nVec++; if (mem[32] !== 32'hA5A5_0001) begin nErr++; $display("FAIL release_mem: got %h want a5a50001", mem[32]); end
    endtask

    task automatic test_dma_read();
        pokeEn   = 1'b1;
        pokeIdx  = 16;
        pokeData = 32'hDEAD_BEEF;
        tick();
        pokeEn       = 1'b0;
        bus.dma_req  = 1'b1;
        bus.dma_we   = 1'b0;
        bus.dma_addr = 32'h40;
        settle();
        nVec++; if (bus.dma_gnt !== 1'b1) begin nErr++; $display("FAIL rd_gnt: got %b want 1", bus.dma_gnt); end
        nVec++; if (bus.core_stall !== 1'b0) begin nErr++; $display("FAIL rd_stall: got %b want 0", bus.core_stall); end
        nVec++; if (bus.mem_A !== 32'h40) begin nErr++; $display("FAIL rd_addr: got %h want 40", bus.mem_A); end
        nVec++; if (bus.mem_WE !== 1'b0) begin nErr++; $display("FAIL rd_we: got %b want 0", bus.mem_WE); end
        tick();
        idle();
        settle();
        nVec++; if (bus.dma_rvalid !== 1'b1) begin nErr++; $display("FAIL rd_rvalid: got %b want 1", bus.dma_rvalid); end
        nVec++; if (bus.dma_rdata !== 32'hDEAD_BEEF) begin nErr++; $display("FAIL rd_data: got %h want deadbeef", bus.dma_rdata); end
        tick();
        settle();
        nVec++; if (bus.dma_rvalid !== 1'b0) begin nErr++; $display("FAIL rd_rvalid_drop: got %b want 0", bus.dma_rvalid); end
        nVec++; if (bus.dma_rdata !== 32'hDEAD_BEEF) begin nErr++; $display("FAIL rd_data_hold: got %h want deadbeef", bus.dma_rdata); end
        tick();
    endtask

    task automatic test_contention();
        idle();
        tick();
        bus.core_req   = 1'b1;
        bus.core_we    = 1'b0;
        bus.core_addr  = 32'h0;
        bus.dma_req    = 1'b1;
        bus.dma_we     = 1'b1;
        bus.dma_addr   = 32'h60;
        bus.dma_wdata  = 32'hC0DE_0001;
        for (int i = 0; i < 8; i++) begin
            logic want;
            want = ((i % (MAX_WAIT + 1)) == MAX_WAIT);
            settle();
            nVec++; if (bus.dma_gnt !== want) begin nErr++; $display("FAIL cont_gnt[%0d]: got %b want %b", i, bus.dma_gnt, want); end
            nVec++; if (bus.core_stall !== want) begin nErr++; $display("FAIL cont_stall[%0d]: got %b want %b", i, bus.core_stall, want); end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_core_store();
        idle();
        tick();
        bus.core_req  = 1'b1;
        bus.core_we   = 1'b0;
        bus.core_addr = 32'h0;
        bus.dma_req   = 1'b1;
        bus.dma_we    = 1'b1;
        bus.dma_addr  = 32'h20;
        bus.dma_wdata = 32'h22;
        for (int i = 0; i < MAX_WAIT; i++) begin
            settle();
            nVec++; if (bus.dma_gnt !== 1'b0) begin nErr++; $display("FAIL st_deny[%0d]: got %b want 0", i, bus.dma_gnt); end
            tick();
        end
        bus.core_we    = 1'b1;
        bus.core_addr  = 32'h10;
        bus.core_wdata = 32'h11;
        settle();
        nVec++; if (bus.core_stall !== 1'b1) begin nErr++; $display("FAIL st_stall: got %b want 1", bus.core_stall); end
        nVec++; if (bus.mem_A !== 32'h20) begin nErr++; $display("FAIL st_dma_addr: got %h want 20", bus.mem_A); end
        nVec++; if (bus.mem_in_Data !== 32'h22) begin nErr++; $display("FAIL st_dma_data: got %h want 22", bus.mem_in_Data); end
        nVec++; if (bus.mem_WE !== 1'b1) begin nErr++; $display("FAIL st_dma_we: got %b want 1", bus.mem_WE); end
        tick();
        nVec++; if (mem[4] !== 32'h0) begin nErr++; $display("FAIL st_stalled_write: got %h want 0", mem[4]); end
        bus.dma_req = 1'b0;
        settle();
        nVec++; if (bus.core_stall !== 1'b0) begin nErr++; $display("FAIL st_unstall: got %b want 0", bus.core_stall); end
        nVec++; if (bus.mem_A !== 32'h10) begin nErr++; $display("FAIL st_core_addr: got %h want 10", bus.mem_A); end
        nVec++; if (bus.mem_in_Data !== 32'h11) begin nErr++; $display("FAIL st_core_data: got %h want 11", bus.mem_in_Data); end
        tick();
        idle();
        tick();
        nVec++; if (mem[4] !== 32'h11) begin nErr++; $display("FAIL st_mem10: got %h want 11", mem[4]); end
        nVec++; if (mem[8] !== 32'h22) begin nErr++; $display("FAIL st_mem20: got %h want 22", mem[8]); end
    endtask

    task automatic test_wait_clear();
        bit dmaReqs [7] = '{1, 1, 0, 1, 1, 1, 1};
        bit wantGnt [7] = '{0, 0, 0, 0, 0, 0, 1};
        idle();
        tick();
        bus.core_req  = 1'b1;
        bus.core_addr = 32'h4;
        bus.dma_we    = 1'b0;
        bus.dma_addr  = 32'h40;
        for (int i = 0; i < 7; i++) begin
            bus.dma_req = dmaReqs[i];
            settle();
            nVec++; if (bus.dma_gnt !== wantGnt[i]) begin nErr++; $display("FAIL clr_gnt[%0d]: got %b want %b", i, bus.dma_gnt, wantGnt[i]); end
            tick();
        end
        idle();
        tick();
    endtask

`ifdef DMEM_ARB_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        nVec++; if (stallCnt !== 32'h0) begin nErr++; $display("FAIL stats_rst_stall: got %0d want 0", stallCnt); end
        nVec++; if (dmaXferCnt !== 32'h0) begin nErr++; $display("FAIL stats_rst_xfer: got %0d want 0", dmaXferCnt); end
        test_contention();
        settle();
        nVec++; if (stallCnt !== 32'd2) begin nErr++; $display("FAIL stats_stall: got %0d want 2", stallCnt); end
        nVec++; if (dmaXferCnt !== 32'd2) begin nErr++; $display("FAIL stats_xfer: got %0d want 2", dmaXferCnt); end
        tick();
    endtask
`endif

    task automatic test_random();
        logic lastHeld;
        int   bad;
        lastHeld = 1'b0;
        for (int c = 0; c < 600; c++) begin
            // A denied master keeps its request frozen until granted.
            if (!lastHeld) begin
                bus.dma_req   = ($urandom_range(0, 99) < 60);
                bus.dma_we    = $urandom_range(0, 1) == 1;
                bus.dma_addr  = 32'($urandom_range(0, 255)) << 2;
                bus.dma_wdata = $urandom;
            end
            bus.core_req   = ($urandom_range(0, 99) < 70);
            bus.core_we    = $urandom_range(0, 1) == 1;
            bus.core_addr  = 32'($urandom_range(0, 255)) << 2;
            bus.core_wdata = $urandom;
            rst            = ($urandom_range(0, 99) < 3);
            settle();
            nVec++; if (bus.dma_gnt !== expGnt) begin nErr++; $display("FAIL rnd_gnt@%0d: got %b want %b", c, bus.dma_gnt, expGnt); end
            nVec++; if (bus.core_stall !== expStall) begin nErr++; $display("FAIL rnd_stall@%0d: got %b want %b", c, bus.core_stall, expStall); end
            nVec++; if (bus.mem_WE !== expWe) begin nErr++; $display("FAIL rnd_we@%0d: got %b want %b", c, bus.mem_WE, expWe); end
            nVec++; if (bus.mem_A !== expA) begin nErr++; $display("FAIL rnd_addr@%0d: got %h want %h", c, bus.mem_A, expA); end
            if (expWe) begin
                nVec++; if (bus.mem_in_Data !== expWd) begin nErr++; $display("FAIL rnd_wdata@%0d: got %h want %h", c, bus.mem_in_Data, expWd); end
            end
            nVec++; if (bus.core_rdata !== refMem[widx(expA)]) begin nErr++; $display("FAIL rnd_crdata@%0d: got %h want %h", c, bus.core_rdata, refMem[widx(expA)]); end
            nVec++; if (bus.dma_rvalid !== expRvalid) begin nErr++; $display("FAIL rnd_rvalid@%0d: got %b want %b", c, bus.dma_rvalid, expRvalid); end
            nVec++; if (bus.dma_rdata !== expRdata) begin nErr++; $display("FAIL rnd_rdata@%0d: got %h want %h", c, bus.dma_rdata, expRdata); end
            lastHeld = bus.dma_req && !expGnt;
            tick();
        end
        rst = 1'b0;
        idle();
        tick();
        settle();
        nVec++; if (bus.dma_rvalid !== expRvalid) begin nErr++; $display("FAIL rnd_final_rvalid: got %b want %b", bus.dma_rvalid, expRvalid); end
`ifdef DMEM_ARB_STATS_EN
        nVec++; if (stallCnt !== expStallCnt) begin nErr++; $display("FAIL rnd_stall_cnt: got %0d want %0d", stallCnt, expStallCnt); end
        nVec++; if (dmaXferCnt !== expXferCnt) begin nErr++; $display("FAIL rnd_xfer_cnt: got %0d want %0d", dmaXferCnt, expXferCnt); end
`endif
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== refMem[i]) bad++;
        end
        nVec++; if (bad != 0) begin nErr++; $display("FAIL rnd_mem_image: %0d words differ, want 0", bad); end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) refMem[i] = 32'h0;
        denied         = 0;
        expRvalid      = 1'b0;
        expRdata       = 32'h0;
        expStallCnt    = 32'h0;
        expXferCnt     = 32'h0;
        pokeEn         = 1'b0;
        pokeIdx        = 0;
        pokeData       = 32'h0;
        rst            = 1'b1;
        bus.core_req   = 1'b0;
        bus.core_we    = 1'b0;
        bus.core_addr  = 32'h0;
        bus.core_wdata = 32'h0;
        bus.dma_req    = 1'b0;
        bus.dma_we     = 1'b0;
        bus.dma_addr   = 32'h0;
        bus.dma_wdata  = 32'h0;
        @(posedge clk);
        #1;

        test_reset();
        test_dma_read();
        test_contention();
        test_core_store();
        test_wait_clear();
`ifdef DMEM_ARB_STATS_EN
        test_stats();
`endif
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
